// File: rtl/cqu_wb_pkg.sv
// Shared constants for the writeback / register-file slice.
package cqu_wb_pkg;
    localparam int DEF_DATA_W = 32;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_writer_load_align.sv
// Little-endian load alignment and sign/zero extension of a raw memory word.
module load_align
    import cqu_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_data[{addr_lo, 3'b000} +: 8];
    // Halfword loads ignore the low address bit.
    assign half_sel = mem_data[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mem_data;
        case (load_type)
            LT_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = mem_data;
        endcase
    end
endmodule

// File: rtl/wb_regfile_writer.sv
// Writeback stage: one-entry WB register, GPR file with two read ports, forwarding tap, retire counter.
// Optional write-through read bypass when WB_BYPASS_EN is defined.
module wb_regfile_writer
    import cqu_wb_pkg::*;
#(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  CNT_W    = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic [DATA_W-1:0] rs_rdata,
    output logic [DATA_W-1:0] rt_rdata,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);
    logic              wb_valid_q;
    logic              wb_done_q;
    logic              fwd_valid_q;
    logic [AW-1:0]     wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] wb_data_d;
    logic [DATA_W-1:0] load_data;
    logic [CNT_W-1:0]  retire_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              we;

    assign in_ready = !stall;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .mem_data  (in_mem_data),
        .load_type (in_load_type),
        .addr_lo   (in_addr_lo),
        .load_data (load_data)
    );

    assign wb_data_d = in_mem_to_reg ? load_data : in_alu_result;

    // fwd_valid_q already folds in reg_write and rd != 0; wb_done blocks repeat writes while stalled.
    assign we = fwd_valid_q && !wb_done_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wb_valid_q  <= 1'b0;
            wb_done_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            retire_q    <= '0;
        end else begin
            if (wb_valid_q && !wb_done_q)
                retire_q <= retire_q + CNT_W'(1);
            if (stall) begin
                wb_done_q <= wb_done_q | wb_valid_q;
            end else if (in_valid) begin
                wb_valid_q  <= 1'b1;
                wb_done_q   <= 1'b0;
                fwd_valid_q <= in_reg_write && (in_rd != REG_ZERO);
                wb_rd_q     <= in_rd;
                wb_data_q   <= wb_data_d;
            end else begin
                wb_valid_q  <= 1'b0;
                wb_done_q   <= 1'b0;
                fwd_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (we) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    always_comb begin
        rs_rdata = regs_q[rs_addr];
        rt_rdata = regs_q[rt_addr];
`ifdef WB_BYPASS_EN
        if (fwd_valid_q && (rs_addr == wb_rd_q))
            rs_rdata = wb_data_q;
        if (fwd_valid_q && (rt_addr == wb_rd_q))
            rt_rdata = wb_data_q;
`endif
        if (rs_addr == REG_ZERO)
            rs_rdata = '0;
        if (rt_addr == REG_ZERO)
            rt_rdata = '0;
    end

    assign fwd_valid    = fwd_valid_q;
    assign fwd_rd       = wb_rd_q;
    assign fwd_data     = wb_data_q;
    assign retire_count = retire_q;
endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Writeback end of the register-file interface. It accepts retiring results from the MEM stage over a valid/ready handshake and holds them in a one-entry WB register.
- Aligns and extends load data, then writes the 32x32 general-purpose register file it owns.
- Supplies the two combinational read ports consumed by the decode stage, plus a forwarding tap and a retired-instruction counter.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is clog2(NUM_REGS)=5.
- DATA_W, 32, register and datapath width.
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline stall; holds the WB entry and blocks acceptance
- in_valid  in  1  MEM stage offers a result
- in_ready  out  1  WB can accept; equals !stall
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes a register
- in_mem_to_reg  in  1  1 selects load data, 0 selects ALU result
- in_alu_result  in  32  ALU result
- in_mem_data  in  32  raw memory word
- in_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
- in_addr_lo  in  2  byte offset of the load address
- rs_addr  in  5  read port A address
- rt_addr  in  5  read port B address
- rs_rdata  out  32  read port A data (combinational)
- rt_rdata  out  32  read port B data (combinational)
- fwd_valid  out  1  WB entry will write a register
- fwd_rd  out  5  WB entry destination
- fwd_data  out  32  WB entry final write data
- retire_count  out  32  number of instructions retired

Behaviour:
- Reset (rstn=1, asynchronous):
  - All 32 registers cleared.
  - wb_valid=0, wb_done=0, retire_count=0.
  - fwd_valid=0, fwd_rd=0, fwd_data=0.
  - in_ready follows !stall during reset.
  - A reset asserted mid-operation discards the WB entry without writing it.
- Capture:
  - When in_valid && in_ready at edge N, the WB register loads the rd, control fields and final data (data computed on capture).
  - wb_valid=1 and wb_done=0 during cycle N+1.
  - When !stall && !in_valid, wb_valid clears at the edge.
  - When stall=1, the WB entry is held unchanged.
- Write:
  - we = wb_valid && wb_reg_write && (wb_rd!=0) && !wb_done.
  - The register file is written at the end of cycle N+1 and is visible on the read ports in N+2 without bypass.
  - wb_done sets after the write, so a stalled entry writes exactly once.
- Retire counter:
  - retire_count increments once per entry: when wb_valid && !wb_done, regardless of reg_write.
  - Wraps modulo 2^CNT_W.
- Register $0:
  - Always reads 0.
  - Writes to $0 are dropped but still count as retired.
- Load alignment (little-endian), applied when mem_to_reg=1:
  - LB/LBU select byte in_addr_lo; LB sign-extends, LBU zero-extends.
  - LH/LHU select halfword in_addr_lo[1] (bit 0 ignored); LH sign-extends, LHU zero-extends.
  - LW passes the word through.
  - Load type codes 5-7 are treated as LW.
  - When mem_to_reg=0, in_alu_result is used unchanged.
- Forwarding tap:
  - fwd_valid = wb_valid && wb_reg_write && wb_rd!=0.
  - fwd_valid stays asserted while the entry is held (including after wb_done).
  - fwd_rd and fwd_data are the registered values.
- Simultaneous events: a new capture and the write of the old entry happen at the same edge. The old entry's write is not lost, because we is evaluated on the old state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a read port returns wb data when its address equals wb_rd and fwd_valid=1 (write-through bypass). The decode stage then sees the result in cycle N+1. Reads of address 0 still return 0.
- Undefined: read ports return register-file contents only. A write is visible only from the cycle after the write edge.

Decomposition:
- Package cqu_wb_pkg holds:
  - load type constants LT_LW=3'd0, LT_LB=3'd1, LT_LBU=3'd2, LT_LH=3'd3, LT_LHU=3'd4;
  - REG_ZERO=5'd0;
  - DATA_W default.
- One sub-module, load_align: combinational; inputs mem_data, load_type and addr_lo; output is the extended data.

Test Plan:
- Reset then read all addresses -> 0; assert rstn mid-entry -> no write occurs, retire_count=0.
- Capture rd=5, alu_result=0x12345678, reg_write=1 -> fwd_valid=1 in N+1; rs_addr=5 reads 0x12345678 in N+2 (N+1 with WB_BYPASS_EN).
- Load checks with mem_data=0x80FF7F01:
  - LB, addr_lo=3 -> 0xFFFFFF80.
  - LBU, addr_lo=1 -> 0x0000007F.
  - LH, addr_lo=2 -> 0xFFFF80FF.
  - LHU, addr_lo=0 -> 0x00007F01.
  - load_type=6 -> 0x80FF7F01.
- Write rd=0 data 0xDEADBEEF -> $0 reads 0, fwd_valid=0, retire_count increments by 1.
- Stall held 3 cycles over a valid entry -> single write, retire_count +1 only, in_ready=0 throughout, fwd outputs stable.
- Back-to-back captures to rd=7 (0x1, then 0x2) -> final value 0x2; retire_count=2.
